dma_bus_arbiter: RTL
====================

Name: dma_bus_arbiter

Overview:
- Shares the processor's local multiplexed bus between NREQ bus-master requesters, such as DMA channels and the refresh engine.
- Requests the bus from processor_8088 through its hold/hlda handshake.
- Once hlda is seen, grants the bus to exactly one requester, chosen by rotating priority.
- Returns the bus to the CPU after every ownership, guaranteeing at least GAP_CYCLES of CPU tenure between masters.

Parameters:
- NREQ, 4: number of requesters; valid range 2..8.
- GAP_CYCLES, 2: clocks the arbiter stays out of IDLE after hlda falls; valid range 1..15.
- ACK_TIMEOUT, 64: clocks in WAIT_ACK before ack_err is raised; valid range 2..255.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester level request; a requester holds it high for its whole tenure.
- hlda  in  1  hold acknowledge from processor_8088.
- hold  out  1  bus request to processor_8088.
- gnt  out  NREQ  one-hot grant; all zeros when no requester owns the bus.
- gnt_id  out  $clog2(NREQ)  index of the current or last owner.
- bus_busy  out  1  high when any gnt bit is high.
- ack_err  out  1  sticky; hlda did not arrive within ACK_TIMEOUT clocks.
- proto_err  out  1  sticky; hlda fell while a grant was active.

Behaviour:
- Reset: rst low clears everything immediately, whatever the current state:
  - hold, gnt, gnt_id, bus_busy, ack_err and proto_err all go to 0;
  - the state goes to IDLE;
  - the rotate pointer goes to 0;
  - the gap and timeout counters go to 0.
- All outputs are registered.
- States: IDLE, WAIT_ACK, OWN, RELEASE, GAP.
- IDLE:
  - If req is nonzero, hold goes to 1 on the next edge and the state moves to WAIT_ACK.
  - hlda in IDLE is ignored.
- WAIT_ACK:
  - hold stays at 1 and the timeout counter increments each clock.
  - When the count reaches ACK_TIMEOUT, ack_err goes to 1. The state stays in WAIT_ACK; hold must never be withdrawn before hlda.
  - When hlda is sampled 1 and req is nonzero: the winner is picked from req at that edge; gnt and gnt_id load on the same edge; the pointer becomes winner+1 mod NREQ; the state moves to OWN.
  - When hlda is sampled 1 and req is zero (all requests withdrawn): no grant is issued and the state moves to RELEASE.
- Latency, with no contention and hlda returned combinationally:
  - req rises before edge 0;
  - hold is high after edge 0;
  - hlda is sampled high at edge n;
  - gnt is high after edge n.
- Rotating priority:
  - The search starts at the pointer and proceeds upward, wrapping past NREQ-1 to 0.
  - The first set req bit wins.
  - Several requests arriving together are resolved by this rule alone.
- OWN:
  - The grant is held while req[gnt_id] is 1. Other requests are ignored during ownership.
  - When req[gnt_id] drops: gnt goes to 0, hold goes to 0 and the state moves to RELEASE, all on the same edge.
  - If hlda is sampled 0 while in OWN: proto_err goes to 1, and gnt and hold go to 0 on that edge. The state moves to RELEASE.
  - Requests are never granted back-to-back; the bus always returns to the CPU first.
- RELEASE:
  - hold is 0 in this state.
  - Wait for hlda to be sampled 0, then load the gap counter and move to GAP.
- GAP:
  - Count GAP_CYCLES clocks, then move to IDLE.
  - Requests that arrive during GAP are honoured from IDLE.
- bus_busy is equal to the OR of gnt every cycle.
- gnt_id keeps its value outside OWN.

Decomposition:
- Shared package (bus_pkg):
  - state encodings: IDLE=0, WAIT_ACK=1, OWN=2, RELEASE=3, GAP=4;
  - the width helper for gnt_id.
- Sub-module dma_rr_picker: combinational rotating-priority encoder.
  - Inputs: req, ptr.
  - Outputs: win_id, win_valid.
- Gap and timeout counters reuse the existing counter module.

Test Plan:
- Single request: req=4'b0010, hlda follows hold after 3 clocks.
  - Required: hold rises 1 clock after req.
  - Required: gnt=4'b0010 and gnt_id=1 one clock after hlda is sampled.
  - Then drop req: gnt and hold both go to 0 on the next edge.
  - Required: after hlda falls, IDLE is re-entered after exactly 2 clocks.
- Rotation fairness: req=4'b1111 held constant through repeated tenures.
  - Required: grants in order id 0,1,2,3,0, with one release/gap sequence between each.
- Withdraw before ack: req=4'b0100 pulses 1 clock, hlda arrives 5 clocks later.
  - Required: gnt is never asserted.
  - Required: hold stays 1 until hlda, then falls.
  - Required: the state passes through RELEASE.
- Ack timeout: req=4'b0001, hlda held 0.
  - Required: ack_err rises on the 64th clock in WAIT_ACK, and hold remains 1.
  - Then raise hlda: gnt=4'b0001 on the next clock, and ack_err stays 1.
- Protocol error: in OWN with id 2, force hlda to 0.
  - Required: proto_err=1, gnt=0 and hold=0 after the next edge.
  - Required: the state moves to RELEASE.
- Reset mid-OWN: assert rst low asynchronously, between clock edges.
  - Required: hold, gnt, bus_busy and both error flags go to 0 immediately, without waiting for a clock edge.
  - Required: with req=4'b1000 after rst deasserts, the first grant goes to id 3 and the pointer search starts at 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the DMA bus arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_pkg;

  // Arbiter FSM encodings; values are fixed so debug tools can decode them.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ACK = 3'd1,
    OWN      = 3'd2,
    RELEASE  = 3'd3,
    GAP      = 3'd4
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_counter.sv
// Generic up/down counter used for timeouts and gap timing.
// Latency: count updates one clock after clr/load/inc/dec.
// Backpressure: none; priority is clr > load > inc > dec.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   clr            force count to zero
//   load, load_val load an explicit value
//   inc, dec       count up / count down by one (no wrap protection)
//   count          current value
module dma_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + W'(1);
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/dma_rr_picker.sv
// Combinational rotating-priority encoder for bus requesters.
// Latency: zero (pure combinational).
// Backpressure: none; win_valid is low when no request is pending.
//
// Ports:
//   req        per-requester request vector
//   ptr        index where the priority search starts
//   win_id     first set request at or above ptr, wrapping to 0
//   win_valid  high when any request bit is set
module dma_rr_picker
  import bus_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]             req,
  input  logic [id_width(NREQ)-1:0]   ptr,
  output logic [id_width(NREQ)-1:0]   win_id,
  output logic                        win_valid
);

  localparam int IDW = id_width(NREQ);

  // One extra bit so ptr + offset can exceed NREQ-1 before the wrap.
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    win_id    = '0;
    win_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_id    = idx;
      end
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the CPU local bus among NREQ masters via the hold/hlda handshake.
// Latency: hold one clock after req; gnt one clock after hlda is sampled high.
// Backpressure: hold stays up until hlda; bus always returns to CPU between masters.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   req        per-requester level request, held for the whole tenure
//   hlda       hold acknowledge from the CPU
//   hold       bus request to the CPU
//   gnt        one-hot grant, zero when nobody owns the bus
//   gnt_id     index of the current or last owner
//   bus_busy   OR of gnt
//   ack_err    sticky: hlda did not arrive within ACK_TIMEOUT clocks
//   proto_err  sticky: hlda fell while a grant was active
module dma_bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic                      hlda,
  output logic                      hold,
  output logic [NREQ-1:0]           gnt,
  output logic [id_width(NREQ)-1:0] gnt_id,
  output logic                      bus_busy,
  output logic                      ack_err,
  output logic                      proto_err
);

  localparam int             IDW      = id_width(NREQ);
  localparam logic [7:0]     TO_MAX   = 8'(ACK_TIMEOUT);
  localparam logic [7:0]     TO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0]     GAP_LOAD = 4'(GAP_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic           hold_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IDW-1:0] gnt_id_nxt;
  logic           ack_err_nxt;
  logic           proto_err_nxt;

  logic           to_clr, to_inc;
  logic [7:0]     to_cnt;
  logic           gap_load, gap_dec;
  logic [3:0]     gap_cnt;

  logic [IDW-1:0] win_id;
  logic           win_valid;

  dma_rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req       (req),
    .ptr       (ptr),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  // Clocks spent waiting for hlda; saturates at ACK_TIMEOUT.
  dma_counter #(
    .W (8)
  ) u_to_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (to_clr),
    .load     (1'b0),
    .load_val (8'd0),
    .inc      (to_inc),
    .dec      (1'b0),
    .count    (to_cnt)
  );

  // Remaining CPU-tenure clocks before a new hold may be raised.
  dma_counter #(
    .W (4)
  ) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .inc      (1'b0),
    .dec      (gap_dec),
    .count    (gap_cnt)
  );

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    hold_nxt      = hold;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    ack_err_nxt   = ack_err;
    proto_err_nxt = proto_err;
    to_clr        = 1'b0;
    to_inc        = 1'b0;
    gap_load      = 1'b0;
    gap_dec       = 1'b0;

    unique case (state)
      IDLE: begin
        hold_nxt = 1'b0;
        if (|req) begin
          hold_nxt  = 1'b1;
          to_clr    = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        // hold is never withdrawn here, even after a timeout.
        hold_nxt = 1'b1;
        if (hlda) begin
          if (win_valid) begin
            gnt_nxt    = ONE_HOT0 << win_id;
            gnt_id_nxt = win_id;
            ptr_nxt    = (win_id == LAST_ID) ? '0 : win_id + IDW'(1);
            state_nxt  = OWN;
          end else begin
            // Everyone withdrew: hand the bus straight back.
            hold_nxt  = 1'b0;
            state_nxt = RELEASE;
          end
        end else begin
          if (to_cnt != TO_MAX) begin
            to_inc = 1'b1;
          end
          if (to_cnt == TO_LAST) begin
            ack_err_nxt = 1'b1;
          end
        end
      end

      OWN: begin
        if (!hlda) begin
          proto_err_nxt = 1'b1;
          gnt_nxt       = '0;
          hold_nxt      = 1'b0;
          state_nxt     = RELEASE;
        end else if (!req[gnt_id]) begin
          gnt_nxt   = '0;
          hold_nxt  = 1'b0;
          state_nxt = RELEASE;
        end
      end

      RELEASE: begin
        hold_nxt = 1'b0;
        if (!hlda) begin
          gap_load  = 1'b1;
          state_nxt = GAP;
        end
      end

      GAP: begin
        hold_nxt = 1'b0;
        if (gap_cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end

      default: begin
        hold_nxt  = 1'b0;
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold      <= 1'b0;
      gnt       <= '0;
      gnt_id    <= '0;
      bus_busy  <= 1'b0;
      ack_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold      <= hold_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      bus_busy  <= |gnt_nxt;
      ack_err   <= ack_err_nxt;
      proto_err <= proto_err_nxt;
    end
  end

endmodule
